// File: rtl/musb_pipe_stage_register_pkg.sv
// Shared definitions for the MUSB pipeline stage register: state encodings,
// main-slot source selection and per-stage control bubble constants.
package musb_pipe_stage_register_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    typedef enum logic [1:0] {
        MAIN_HOLD      = 2'd0,
        MAIN_FROM_IN   = 2'd1,
        MAIN_FROM_SKID = 2'd2
    } main_src_t;

    typedef enum logic [2:0] {
        STAGE_IF  = 3'd0,
        STAGE_ID  = 3'd1,
        STAGE_EX  = 3'd2,
        STAGE_MEM = 3'd3,
        STAGE_WB  = 3'd4
    } pipe_stage_t;

    localparam int unsigned PIPE_CTRL_W = 8;

    // Every stage currently idles with all control bits cleared; kept per stage
    // so a stage that needs a non-zero bubble only has to change here.
    function automatic logic [PIPE_CTRL_W-1:0] ctrl_bubble(pipe_stage_t stage);
        logic [PIPE_CTRL_W-1:0] value;
        value = '0;
        case (stage)
            STAGE_IF:  value = 8'h00;
            STAGE_ID:  value = 8'h00;
            STAGE_EX:  value = 8'h00;
            STAGE_MEM: value = 8'h00;
            STAGE_WB:  value = 8'h00;
            default:   value = '0;
        endcase
        return value;
    endfunction

    function automatic logic [1:0] state_level(stage_state_t state);
        return 2'(state);
    endfunction

    function automatic logic state_ready(stage_state_t state);
        return state != ST_TWO;
    endfunction

endpackage

// File: rtl/musb_pipe_stage_register_if.sv
// Upstream/downstream handshake bundle of one pipeline stage register.
// slave: the stage itself; master: the surrounding pipeline (or a bench).
interface musb_pipe_stage_register_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_ctrl,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_ctrl,
        output out_data
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_ctrl,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_ctrl,
        input  out_data
    );
endinterface

// File: rtl/musb_pipe_skid_slot.sv
// Load-enable holding register for the second (skid) entry of a stage register.
module musb_pipe_skid_slot #(
    parameter int unsigned W = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/musb_pipe_stage_register.sv
// Two-entry pipeline stage register: main slot drives the outputs, a skid slot
// absorbs one extra entry so in_ready can be a plain flop.
module musb_pipe_stage_register
    import musb_pipe_stage_register_pkg::*;
#(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       CTRL_W      = 8,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    musb_pipe_stage_register_if.slave     bus,
    output logic [1:0]                    level
);

    stage_state_t      state;
    stage_state_t      state_nx;
    main_src_t         main_src;
    logic              skid_load;
    logic              in_ready_q;
    logic              out_valid;
    logic              accept;
    logic              deliver;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign out_valid = (state != ST_EMPTY);
    assign accept    = bus.in_valid & in_ready_q;
    assign deliver   = out_valid & bus.out_ready;

    always_comb begin
        state_nx  = state;
        main_src  = MAIN_HOLD;
        skid_load = 1'b0;
        if (flush) begin
            state_nx = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nx = ST_ONE;
                        main_src = MAIN_FROM_IN;
                    end
                end
                ST_ONE: begin
                    case ({accept, deliver})
                        2'b11: main_src = MAIN_FROM_IN;
                        2'b10: begin
                            state_nx  = ST_TWO;
                            skid_load = 1'b1;
                        end
                        2'b01: state_nx = ST_EMPTY;
                        default: state_nx = ST_ONE;
                    endcase
                end
                ST_TWO: begin
                    if (deliver) begin
                        state_nx = ST_ONE;
                        main_src = MAIN_FROM_SKID;
                    end
                end
                default: state_nx = ST_EMPTY;
            endcase
        end
    end

    // in_ready is registered from the next state, so it never sees out_ready
    // combinationally; TWO is the only state that refuses input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nx;
            in_ready_q <= state_ready(state_nx);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_ctrl <= '0;
            main_data <= '0;
        end else begin
            case (main_src)
                MAIN_FROM_IN: begin
                    main_ctrl <= bus.in_ctrl;
                    main_data <= bus.in_data;
                end
                MAIN_FROM_SKID: begin
                    main_ctrl <= skid_ctrl;
                    main_data <= skid_data;
                end
                default: begin
                    main_ctrl <= main_ctrl;
                    main_data <= main_data;
                end
            endcase
        end
    end

    musb_pipe_skid_slot #(
        .W(CTRL_W + DATA_W)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    ({bus.in_ctrl, bus.in_data}),
        .q    ({skid_ctrl, skid_data})
    );

    // Payload is left in place when idle; only the control field is masked.
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.out_ctrl  = out_valid ? main_ctrl : CTRL_BUBBLE;
    assign bus.out_data  = main_data;
    assign level         = state_level(state);

endmodule
